instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 11 +
 rtl/pc_unit.sv | 43 ++++
 rtl/instr_fetch.sv | 84 ++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register, next-PC selection and bad-PC check
module pc_unit
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_target,
   input  logic        advance,
   input  logic [63:0] br_target,
   output logic [63:0] pc,
   output logic        pc_bad
);

   logic [63:0] pc_q;
   logic [63:0] pc_d;
   logic [64:0] last_byte;

   always_comb begin
      pc_d = pc_q;
      if (load_target) begin
         pc_d = br_target;
      end else if (advance) begin
         pc_d = pc_q + 64'(INSTR_BYTES);
      end
   end

   // One extra bit so a PC near 2^64 cannot wrap past the memory limit check.
   assign last_byte = {1'b0, pc_q} + 65'(INSTR_BYTES - 1);
   assign pc_bad    = (pc_q[1:0] != 2'b00) || (last_byte >= 65'(MEM_SIZE));
   assign pc        = pc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: IF/ID register, RUN/FAULT control, delivered-instruction counter
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   output logic        ifid_valid,
   output logic [63:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        fault,
   output logic [31:0] fetch_count
);

   fetch_state_t state;
   fetch_state_t state_n;
   logic         pc_bad;
   logic         load_target;
   logic         do_fetch;
   logic         go_fault;

   pc_unit #(
      .MEM_SIZE (MEM_SIZE),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_target (load_target),
      .advance     (do_fetch),
      .br_target   (br_target),
      .pc          (imem_addr),
      .pc_bad      (pc_bad)
   );

   // Branch outranks stall; nothing moves once faulted.
   always_comb begin
      state_n     = state;
      load_target = 1'b0;
      do_fetch    = 1'b0;
      go_fault    = 1'b0;
      if (state == RUN) begin
         if (br_taken) begin
            load_target = 1'b1;
         end else if (!stall) begin
            if (pc_bad) begin
               go_fault = 1'b1;
               state_n  = FAULT;
            end else begin
               do_fetch = 1'b1;
            end
         end
      end
   end

   assign fault = (state == FAULT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RUN;
         ifid_valid  <= 1'b0;
         ifid_pc     <= 64'd0;
         ifid_instr  <= 32'd0;
         fetch_count <= 32'd0;
      end else begin
         state <= state_n;
         if (load_target || go_fault) begin
            ifid_valid <= 1'b0;
         end else if (do_fetch) begin
            ifid_valid  <= 1'b1;
            ifid_pc     <= imem_addr;
            ifid_instr  <= imem_instr;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed plus randomized bench for instr_fetch against a behavioural model
module tb_instr_fetch;

   localparam int unsigned MEM_SIZE = 1024;

   logic        clk;
   logic        reset_n;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        br_taken;
   logic [63:0] br_target;
   logic        ifid_valid;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        fault;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_pc;
   logic        m_valid;
   logic [63:0] m_ifid_pc;
   logic [31:0] m_ifid_instr;
   logic        m_fault;
   logic [31:0] m_count;

   instr_fetch #(
      .MEM_SIZE (MEM_SIZE),
      .RESET_PC (64'd0)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .ifid_valid  (ifid_valid),
      .ifid_pc     (ifid_pc),
      .ifid_instr  (ifid_instr),
      .fault       (fault),
      .fetch_count (fetch_count)
   );

   // Read-only instruction memory: word k holds 0x1000_0000 + k.
   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      return 32'h1000_0000 + 32'(addr >> 2);
   endfunction

   assign imem_instr = mem_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".imem_addr"},   imem_addr,   m_pc);
      chk({tag, ".ifid_valid"},  64'(ifid_valid), 64'(m_valid));
      chk({tag, ".ifid_pc"},     ifid_pc,     m_ifid_pc);
      chk({tag, ".ifid_instr"},  64'(ifid_instr), 64'(m_ifid_instr));
      chk({tag, ".fault"},       64'(fault),  64'(m_fault));
      chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(m_count));
   endtask

   task automatic model_reset();
      m_pc         = 64'd0;
      m_valid      = 1'b0;
      m_ifid_pc    = 64'd0;
      m_ifid_instr = 32'd0;
      m_fault      = 1'b0;
      m_count      = 32'd0;
   endtask

   // One clock of the fetch rules, evaluated on the values present before the edge.
   task automatic model_edge(input logic s, input logic b, input logic [63:0] t);
      if (m_fault) return;
      if (b) begin
         m_pc    = t;
         m_valid = 1'b0;
      end else if (!s) begin
         if (m_pc % 4 != 0 || m_pc > 64'(MEM_SIZE - 4)) begin
            m_fault = 1'b1;
            m_valid = 1'b0;
         end else begin
            m_ifid_pc    = m_pc;
            m_ifid_instr = mem_word(m_pc);
            m_valid      = 1'b1;
            m_pc         = m_pc + 64'd4;
            m_count      = m_count + 32'd1;
         end
      end
   endtask

   task automatic step(input string tag, input logic s, input logic b, input logic [63:0] t);
      stall     = s;
      br_taken  = b;
      br_target = t;
      model_edge(s, b, t);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Assert reset between edges, confirm it acts at once, hold over edges, release mid-cycle.
   task automatic do_reset(input string tag);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all({tag, ".async"});
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b1;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 64'd0;
      model_reset();
      #3;
      reset_n = 1'b0;
      #1;
      check_all("por");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Straight-line fetch of four words.
      for (int i = 0; i < 4; i++) step("seq4", 1'b0, 1'b0, 64'd0);
      chk("seq4.pc_last", ifid_pc, 64'd12);
      chk("seq4.instr_last", 64'(ifid_instr), 64'h1000_0003);
      chk("seq4.count", 64'(fetch_count), 64'd4);

      // Stall holds everything with ifid_pc=8.
      do_reset("rst1");
      for (int i = 0; i < 3; i++) step("pre_stall", 1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 64'd0);
      chk("stall.addr", imem_addr, 64'd12);
      chk("stall.ifid_pc", ifid_pc, 64'd8);
      chk("stall.count", 64'(fetch_count), 64'd3);
      step("unstall", 1'b0, 1'b0, 64'd0);
      chk("unstall.ifid_pc", ifid_pc, 64'd12);

      // Branch wins over a simultaneous stall.
      step("br_stall", 1'b1, 1'b1, 64'h40);
      chk("br_stall.valid", 64'(ifid_valid), 64'd0);
      step("br_tgt", 1'b0, 1'b0, 64'd0);
      chk("br_tgt.pc", ifid_pc, 64'h40);
      chk("br_tgt.instr", 64'(ifid_instr), 64'h1000_0010);

      // Randomized traffic with aligned in-range targets; running off the end is allowed.
      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
              64'({$urandom_range(0, 255), 2'b00}));
      end

      // Last word of memory is delivered, the next address faults.
      do_reset("rst2");
      step("end_br", 1'b0, 1'b1, 64'd1016);
      step("end_1016", 1'b0, 1'b0, 64'd0);
      step("end_1020", 1'b0, 1'b0, 64'd0);
      chk("end.pc_1020", ifid_pc, 64'd1020);
      step("end_fault", 1'b0, 1'b0, 64'd0);
      chk("end.fault", 64'(fault), 64'd1);
      chk("end.addr", imem_addr, 64'd1024);
      for (int i = 0; i < 4; i++) begin
         step("end_frozen", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'h80);
      end

      // Reset from FAULT is immediate and fetch restarts at RESET_PC.
      do_reset("rst3");
      chk("rst3.fault", 64'(fault), 64'd0);
      step("restart", 1'b0, 1'b0, 64'd0);
      chk("restart.pc", ifid_pc, 64'd0);

      // Misaligned branch target is taken silently, faults on fetch.
      step("bad_br", 1'b0, 1'b1, 64'h42);
      chk("bad_br.fault_pending", 64'(fault), 64'd0);
      step("bad_fetch", 1'b0, 1'b0, 64'd0);
      chk("bad_fetch.fault", 64'(fault), 64'd1);
      chk("bad_fetch.addr", imem_addr, 64'h42);
      step("bad_ign_br", 1'b0, 1'b1, 64'h10);
      step("bad_ign_stall", 1'b1, 1'b0, 64'd0);
      chk("bad_ign.addr", imem_addr, 64'h42);
      chk("bad_ign.valid", 64'(ifid_valid), 64'd0);

      do_reset("rst4");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
